score_tally: RTL and testbench
==============================

// Module: score_tally
// PURPOSE
//  Consumer end of the dropper score/finish interface. Watches every dropper lane's
//  score flag and finish flag, and turns each lane's finish into one judged event
//  (HIT or MISS). Accumulates score, hit/miss counts, current combo and max combo.
//  Sits between the dropper array and the HUD/text renderer; single frame_clk domain.
// PARAMETERS
//  NUM_DROPS      32    number of dropper lanes observed
//  POINTS_PER_HIT 10    base points per hit
//  BONUS_PER_HIT  5     extra points per hit while combo >= COMBO_BONUS_AT
//  COMBO_BONUS_AT 10    combo threshold (pre-update value) for the bonus
//  MAX_SCORE      9999  total_score saturation value (must fit 14 bits)
// PORTS
//  frame_clk      in   1          sole clock; all state updates on posedge
//  Reset          in   1          asynchronous, active-high; forces IDLE, clears all
//  keycode        in   8          primary key; 8'h2c = start, 8'h01 = return to idle
//  keycode_second in   8          secondary key; same decode as keycode
//  score_vec      in   NUM_DROPS  per-lane hit flag (level, valid when lane finishes)
//  done_vec       in   NUM_DROPS  per-lane finished flag (level, 1 while lane in End)
//  total_score    out  14         accumulated points, saturating at MAX_SCORE
//  hit_count      out  8          hits this game, saturating at 255
//  miss_count     out  8          misses this game, saturating at 255
//  combo          out  8          consecutive hits since last miss, saturating at 255
//  max_combo      out  8          highest combo reached this game
//  playing        out  1          1 in PLAY
//  game_over      out  1          1 in OVER
//  full_combo     out  1          1 in OVER when miss_count == 0 and hit_count > 0
// BEHAVIOUR
//  - Reset (async): state = IDLE; all counters, done_q and outputs = 0.
//  - FSM, registered:
//    IDLE -> PLAY when either key == 8'h2c.
//    PLAY -> OVER when &done_vec is 1 (all lanes finished), evaluated after this
//      cycle's events are tallied.
//    PLAY -> IDLE / OVER -> IDLE when either key == 8'h01. 8'h01 has priority over
//      every other transition.
//    All other cases: hold state.
//  - IDLE: counters held at 0 every cycle; done_q <= done_vec, so stale finish
//    flags are never counted.
//  - Event detect (PLAY only): rise = done_vec & ~done_q; done_q <= done_vec.
//    hits_now   = popcount(rise & score_vec).
//    misses_now = popcount(rise & ~score_vec).
//    score_vec is sampled in the same cycle as the rise.
//  - Outputs are registered; a tallied event is visible one frame_clk after the
//    done_vec rise.
//  - Update per PLAY cycle (all from pre-update values):
//    hit_count  += hits_now   (saturate 255)
//    miss_count += misses_now (saturate 255)
//    combo: 0 if misses_now > 0, else combo + hits_now (saturate 255).
//      Hits that coincide with a miss in the same cycle still count in hit_count
//      and in score, but leave combo at 0.
//    max_combo = max(max_combo, new combo).
//    total_score += hits_now*POINTS_PER_HIT
//                   + (combo >= COMBO_BONUS_AT ? hits_now*BONUS_PER_HIT : 0).
//      Compute the sum at >= 16 bits, then clamp to MAX_SCORE.
//  - OVER: all counters frozen; done_vec activity ignored.
//  - A lane whose done falls and rises again within PLAY counts a second time.
//  - Any Reset assertion mid-game clears everything immediately, without waiting
//    for a clock edge.
// TESTING
//  - Reset, then 8'h2c: playing=1; all counts 0.
//  - Lane 0 done 0->1 with score=1: next cycle hit_count=1, combo=1, total_score=10.
//    Hold done high 5 cycles: no further change.
//  - 12 sequential single-lane hits, then 1 miss: hits 11 and 12 score 15 each;
//    total=10*10+2*15=130, combo=0, max_combo=12, miss_count=1.
//  - Same-cycle rise on 3 lanes (2 hits, 1 miss): hit_count+=2, miss_count+=1,
//    combo=0, total_score+=20.
//  - All NUM_DROPS lanes done, all hits: game_over=1, full_combo=1.
//    Then 8'h01: IDLE, outputs 0.
//    Then 8'h2c while done_vec is still all-ones: no events counted.
//  - Preload total_score=9995, then 1 hit: total_score=9999 (saturated).
//    Async Reset mid-PLAY: outputs 0 without a clock edge.

Source files
------------

// File: rtl/score_tally.sv
// score_tally: turns each dropper lane's finish into a judged HIT or MISS and
// keeps the game tallies (score, hit/miss counts, combo, max combo) for the HUD.
//
//  state | meaning
//  IDLE  | waiting for start key; tallies held at zero, finish flags tracked
//  PLAY  | judging lane finishes and accumulating tallies
//  OVER  | every lane finished; tallies frozen until return-to-idle key
module score_tally #(
  parameter int NUM_DROPS      = 32,
  parameter int POINTS_PER_HIT = 10,
  parameter int BONUS_PER_HIT  = 5,
  parameter int COMBO_BONUS_AT = 10,
  parameter int MAX_SCORE      = 9999
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [7:0]           keycode,
  input  logic [7:0]           keycode_second,
  input  logic [NUM_DROPS-1:0] score_vec,
  input  logic [NUM_DROPS-1:0] done_vec,
  output logic [13:0]          total_score,
  output logic [7:0]           hit_count,
  output logic [7:0]           miss_count,
  output logic [7:0]           combo,
  output logic [7:0]           max_combo,
  output logic                 playing,
  output logic                 game_over,
  output logic                 full_combo
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t               state;
  logic [NUM_DROPS-1:0] done_q;
  logic [NUM_DROPS-1:0] rise;
  logic [31:0]          hits_now;
  logic [31:0]          misses_now;
  logic [31:0]          hit_sum;
  logic [31:0]          miss_sum;
  logic [31:0]          combo_sum;
  logic [31:0]          bonus;
  logic [31:0]          score_sum;
  logic [7:0]           hit_nx;
  logic [7:0]           miss_nx;
  logic [7:0]           combo_nx;
  logic [7:0]           max_nx;
  logic [13:0]          score_nx;
  logic                 key_start;
  logic                 key_idle;

  assign key_start = (keycode == 8'h2c) || (keycode_second == 8'h2c);
  assign key_idle  = (keycode == 8'h01) || (keycode_second == 8'h01);

  // Judge this cycle's finish edges and form saturated next tallies.
  always_comb begin
    rise       = done_vec & ~done_q;
    hits_now   = '0;
    misses_now = '0;
    for (int i = 0; i < NUM_DROPS; i++) begin
      hits_now   = hits_now   + 32'(rise[i] &  score_vec[i]);
      misses_now = misses_now + 32'(rise[i] & ~score_vec[i]);
    end
    hit_sum   = 32'(hit_count)  + hits_now;
    miss_sum  = 32'(miss_count) + misses_now;
    combo_sum = 32'(combo)      + hits_now;
    hit_nx    = (hit_sum  > 32'd255) ? 8'd255 : hit_sum[7:0];
    miss_nx   = (miss_sum > 32'd255) ? 8'd255 : miss_sum[7:0];
    if (misses_now != 32'd0)
      combo_nx = 8'd0;
    else
      combo_nx = (combo_sum > 32'd255) ? 8'd255 : combo_sum[7:0];
    max_nx    = (combo_nx > max_combo) ? combo_nx : max_combo;
    // Bonus keys off the combo held before this cycle's hits.
    bonus     = (32'(combo) >= 32'(COMBO_BONUS_AT)) ? hits_now * 32'(BONUS_PER_HIT) : 32'd0;
    score_sum = 32'(total_score) + hits_now * 32'(POINTS_PER_HIT) + bonus;
    score_nx  = (score_sum > 32'(MAX_SCORE)) ? 14'(MAX_SCORE) : score_sum[13:0];
  end

  // Game FSM with registered tallies and status flags.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      done_q      <= '0;
      total_score <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      combo       <= '0;
      max_combo   <= '0;
      playing     <= 1'b0;
      game_over   <= 1'b0;
      full_combo  <= 1'b0;
    end else begin
      // Tracked in every state so a lane already finished on entry to PLAY never counts.
      done_q <= done_vec;
      if (key_idle || state == IDLE) begin
        total_score <= '0;
        hit_count   <= '0;
        miss_count  <= '0;
        combo       <= '0;
        max_combo   <= '0;
        game_over   <= 1'b0;
        full_combo  <= 1'b0;
        if (!key_idle && key_start) begin
          state   <= PLAY;
          playing <= 1'b1;
        end else begin
          state   <= IDLE;
          playing <= 1'b0;
        end
      end else begin
        case (state)
          PLAY: begin
            total_score <= score_nx;
            hit_count   <= hit_nx;
            miss_count  <= miss_nx;
            combo       <= combo_nx;
            max_combo   <= max_nx;
            if (&done_vec) begin
              state      <= OVER;
              playing    <= 1'b0;
              game_over  <= 1'b1;
              full_combo <= (miss_nx == 8'd0) && (hit_nx != 8'd0);
            end
          end
          OVER: begin
            state <= OVER;
          end
          default: begin
            state   <= IDLE;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_tally.sv
// Bench for score_tally: directed game scenarios plus random lane activity,
// checked every cycle against a behavioural game model.
module tb_score_tally;

  localparam int N = 32;

  logic          frame_clk;
  logic          Reset;
  logic [7:0]    keycode;
  logic [7:0]    keycode_second;
  logic [N-1:0]  score_vec;
  logic [N-1:0]  done_vec;
  logic [13:0]   total_score;
  logic [7:0]    hit_count;
  logic [7:0]    miss_count;
  logic [7:0]    combo;
  logic [7:0]    max_combo;
  logic          playing;
  logic          game_over;
  logic          full_combo;

  int checks = 0;
  int errors = 0;

  score_tally dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .keycode        (keycode),
    .keycode_second (keycode_second),
    .score_vec      (score_vec),
    .done_vec       (done_vec),
    .total_score    (total_score),
    .hit_count      (hit_count),
    .miss_count     (miss_count),
    .combo          (combo),
    .max_combo      (max_combo),
    .playing        (playing),
    .game_over      (game_over),
    .full_combo     (full_combo)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Behavioural game model: 0 idle, 1 playing, 2 over.
  int           m_mode;
  int           m_score, m_hits, m_misses, m_combo, m_max;
  logic [N-1:0] m_prev_done;

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      m_mode = 0; m_score = 0; m_hits = 0; m_misses = 0; m_combo = 0; m_max = 0;
      m_prev_done = '0;
    end else begin
      logic [N-1:0] newly;
      int h, m;
      newly = done_vec & ~m_prev_done;
      h = $countones(newly & score_vec);
      m = $countones(newly & ~score_vec);
      if (keycode == 8'h01 || keycode_second == 8'h01) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (keycode == 8'h2c || keycode_second == 8'h2c) m_mode = 1;
      end else if (m_mode == 1) begin
        m_score = m_score + h * 10 + ((m_combo >= 10) ? h * 5 : 0);
        if (m_score > 9999) m_score = 9999;
        m_hits = (m_hits + h > 255) ? 255 : m_hits + h;
        m_misses = (m_misses + m > 255) ? 255 : m_misses + m;
        if (m > 0) m_combo = 0;
        else m_combo = (m_combo + h > 255) ? 255 : m_combo + h;
        if (m_combo > m_max) m_max = m_combo;
        if (done_vec == {N{1'b1}}) m_mode = 2;
      end
      if (m_mode == 0) begin
        m_score = 0; m_hits = 0; m_misses = 0; m_combo = 0; m_max = 0;
      end
      m_prev_done = done_vec;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output to the model.
  task automatic step();
    @(negedge frame_clk);
    chk("total_score", int'(total_score), m_score);
    chk("hit_count", int'(hit_count), m_hits);
    chk("miss_count", int'(miss_count), m_misses);
    chk("combo", int'(combo), m_combo);
    chk("max_combo", int'(max_combo), m_max);
    chk("playing", int'(playing), int'(m_mode == 1));
    chk("game_over", int'(game_over), int'(m_mode == 2));
    chk("full_combo", int'(full_combo), int'(m_mode == 2 && m_misses == 0 && m_hits > 0));
  endtask

  initial begin
    Reset = 1'b1; keycode = 8'h00; keycode_second = 8'h00;
    score_vec = '0; done_vec = '0;
    step(); step();
    chk("reset_total", int'(total_score), 0);
    chk("reset_playing", int'(playing), 0);
    Reset = 1'b0;
    step();

    // Start and a first single hit.
    keycode = 8'h2c; step(); keycode = 8'h00;
    chk("start_playing", int'(playing), 1);
    chk("start_hits", int'(hit_count), 0);
    done_vec[0] = 1'b1; score_vec[0] = 1'b1; step();
    chk("first_hit_count", int'(hit_count), 1);
    chk("first_hit_combo", int'(combo), 1);
    chk("first_hit_score", int'(total_score), 10);
    repeat (5) step();
    chk("held_done_score", int'(total_score), 10);
    chk("held_done_hits", int'(hit_count), 1);

    // Fresh game: 12 sequential hits then one miss, via the secondary key.
    keycode_second = 8'h01; step(); keycode_second = 8'h00;
    chk("idle_clear_hits", int'(hit_count), 0);
    keycode_second = 8'h2c; step(); keycode_second = 8'h00;
    for (int i = 1; i <= 12; i++) begin
      done_vec[i] = 1'b1; score_vec[i] = 1'b1; step();
    end
    done_vec[13] = 1'b1; score_vec[13] = 1'b0; step();
    chk("seq_total", int'(total_score), 130);
    chk("seq_combo", int'(combo), 0);
    chk("seq_max", int'(max_combo), 12);
    chk("seq_miss", int'(miss_count), 1);
    chk("seq_hits", int'(hit_count), 12);

    // Same-cycle finish on three lanes: two hits, one miss.
    done_vec[16:14] = 3'b111; score_vec[16:14] = 3'b011; step();
    chk("multi_hits", int'(hit_count), 14);
    chk("multi_miss", int'(miss_count), 2);
    chk("multi_combo", int'(combo), 0);
    chk("multi_total", int'(total_score), 150);

    // Full-combo game: every lane finishes as a hit at once.
    keycode = 8'h01; done_vec = '0; score_vec = '0; step();
    keycode = 8'h2c; step(); keycode = 8'h00;
    done_vec = '1; score_vec = '1; step();
    chk("fc_game_over", int'(game_over), 1);
    chk("fc_full_combo", int'(full_combo), 1);
    chk("fc_hits", int'(hit_count), 32);
    chk("fc_total", int'(total_score), 320);
    done_vec = '0; step(); done_vec = '1; step();
    chk("over_frozen_hits", int'(hit_count), 32);
    keycode = 8'h01; step(); keycode = 8'h00;
    chk("back_idle_over", int'(game_over), 0);
    chk("back_idle_total", int'(total_score), 0);
    chk("back_idle_fc", int'(full_combo), 0);
    keycode = 8'h2c; step(); keycode = 8'h00; step();
    chk("stale_done_hits", int'(hit_count), 0);
    chk("stale_done_over", int'(game_over), 1);
    chk("stale_done_fc", int'(full_combo), 0);

    // Drive the score into saturation with 31-lane hit waves.
    keycode = 8'h01; done_vec = '0; step();
    keycode = 8'h2c; step(); keycode = 8'h00;
    repeat (25) begin
      done_vec = 32'h7FFF_FFFF; score_vec = '1; step();
      done_vec = '0; step();
    end
    chk("sat_total", int'(total_score), 9999);
    chk("sat_hits", int'(hit_count), 255);
    chk("sat_combo", int'(combo), 255);
    chk("sat_max", int'(max_combo), 255);

    // Asynchronous reset in the middle of a game.
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_total", int'(total_score), 0);
    chk("async_rst_hits", int'(hit_count), 0);
    chk("async_rst_playing", int'(playing), 0);
    #1 Reset = 1'b0;
    step();

    // Random lane activity, keys and occasional async reset pulses.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 199));
      keycode = (r < 6) ? 8'h2c : ((r == 6) ? 8'h01 : 8'(r));
      keycode_second = (r == 7) ? 8'h01 : ((r == 8) ? 8'h2c : 8'h00);
      done_vec = done_vec ^ ($urandom & $urandom & $urandom);
      score_vec = $urandom;
      if (r == 199) begin
        #2 Reset = 1'b1;
        #1;
        chk("rand_async_rst", int'(hit_count), 0);
        Reset = 1'b0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
